router_sched: RTL and testbench
===============================

# router_sched

Clocked switch allocator and output staging for the three-port (C1, C2, P) tree router. Each cycle it computes the route of every pending 9-bit input packet, arbitrates round-robin among the two inputs that can reach each output, and moves winners into one-entry output registers with valid/ready handshakes. It replaces the three free-running two-way arbiters around the router core with a single synchronous scheduler.

## Interface
- WIDTH, 9, packet width; dest field is packet[8:5], P-port child-select bit is packet[4]
- ADDRESS, 4'b1000, this router's subtree address
- MASK, 4'b1000, bits of the dest field compared against ADDRESS
- CLK  in  1  clock, all state updates on the rising edge
- _RESET  in  1  synchronous, active-low reset
- C1in_valid, C2in_valid, Pin_valid  in  1 each  input packet present
- C1in_data, C2in_data, Pin_data  in  WIDTH each  input packet
- C1in_ready, C2in_ready, Pin_ready  out  1 each  input accepted this cycle
- C1out_valid, C2out_valid, Pout_valid  out  1 each  output register full
- C1out_data, C2out_data, Pout_data  out  WIDTH each  output register contents
- C1out_ready, C2out_ready, Pout_ready  in  1 each  downstream accepts
- C1_gcnt, C2_gcnt, P_gcnt  out  16 each  grant counters, present only with ROUTER_SCHED_STATS_EN

## Operation
- Route, C1 and C2 inputs: if (data[8:5] & MASK) == ADDRESS, C1 goes to C2out and C2 goes to C1out; otherwise both go to Pout.
- Route, P input: data[4]==0 goes to C1out; data[4]==1 goes to C2out.
- U-turns never occur. Candidate pairs per output:
  - C1out from {C2, P}
  - C2out from {C1, P}
  - Pout from {C1, C2}
- Output slot is free when !out_valid or out_ready.
- Per output, with a free slot:
  - one requesting candidate: that candidate is granted.
  - two requesting candidates: the one named by the 1-bit priority pointer is granted.
- Pointer state: 0 favours the first-listed source. After any grant the pointer points to the other source. With no grant it holds.
- Grant: the input's ready is 1 in that cycle and the data is registered into the output; out_valid is 1 next cycle.
- Each input targets exactly one output, so at most one ready per input per cycle.
- A losing or blocked input sees ready=0 and must hold valid and data stable (standard valid/ready; valid is never withdrawn before ready).
- Output handshake: the transfer completes when out_valid && out_ready. out_data is stable while out_valid && !out_ready.
- Reset (_RESET=0 at an edge):
  - all out_valid=0, out_data=0, priority pointers=0, counters=0.
  - all in_ready are forced to 0 combinationally while _RESET=0.
  - Packets held in output registers are discarded.

## Timing
- Latency: input accept at cycle N, out_valid=1 at cycle N+1.
- Throughput: one packet per output per cycle. A full register draining (out_ready=1) may be reloaded in the same cycle.
- in_ready is combinational from in_valid, data route bits, out_valid, out_ready and pointers. It is not a function of in_ready of other ports.
- All three outputs may be granted in the same cycle, e.g. C1→C2out, C2→Pout, P→C1out.
- Pointer and counter update on the same edge as the output register load.
- The first edge with _RESET=1 may already accept packets.

## Configuration
- ROUTER_SCHED_STATS_EN defined:
  - Adds C1_gcnt, C2_gcnt, P_gcnt. Each counts grants into its output.
  - Counters are 16-bit and saturate at 16'hFFFF (no wrap).
  - They reset to 0 with _RESET.
- Not defined: the ports and counters are absent. Scheduling behaviour is identical.

## Test plan
- Routing, ADDRESS=MASK=4'b1000:
  - C1in 9'h1A0 appears on C2out next cycle.
  - C1in 9'h0A0 appears on Pout.
  - Pin 9'h000 appears on C1out.
  - Pin 9'h010 appears on C2out.
  - Each appears 1 cycle after ready.
- Contention: C1in=9'h0A0 and C2in=9'h0A0 valid continuously, Pout_ready=1.
  - Pout alternates C1,C2,C1,C2 starting with C1 after reset.
  - Losers see ready=0.
- Backpressure: hold C2out_ready=0 with C2out full.
  - C1in 9'h1A0 sees ready=0 and C2out_data is unchanged.
  - Raise C2out_ready: the stored packet drains and 9'h1A0 loads the same cycle.
- Concurrency: C1in=9'h1A0, C2in=9'h0A0, Pin=9'h000 in one cycle, all out_ready=1.
  - All three in_ready=1.
  - Next cycle C2out=9'h1A0, Pout=9'h0A0, C1out=9'h000.
- Reset mid-operation: assert _RESET=0 with all three outputs full.
  - Next cycle all out_valid=0 and all in_ready=0 while reset is low.
  - After release, contention resumes favouring the first-listed source.
- Stats (macro on): 70000 back-to-back grants into Pout leave P_gcnt=16'hFFFF; reset returns it to 0.

Source files
------------

// File: rtl/router_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : router_sched                                               |
// | Description : Switch allocator and one-entry output staging for the      |
// |               three-port (C1, C2, P) tree router. Routes each pending    |
// |               input, arbitrates round-robin per output and registers     |
// |               winners behind valid/ready handshakes.                     |
// | Options     : ROUTER_SCHED_STATS_EN adds saturating 16-bit grant         |
// |               counters C1_gcnt, C2_gcnt, P_gcnt.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module router_sched #(
  parameter int         WIDTH   = 9,
  parameter logic [3:0] ADDRESS = 4'b1000,
  parameter logic [3:0] MASK    = 4'b1000
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             C1in_valid,
  input  logic [WIDTH-1:0] C1in_data,
  output logic             C1in_ready,
  input  logic             C2in_valid,
  input  logic [WIDTH-1:0] C2in_data,
  output logic             C2in_ready,
  input  logic             Pin_valid,
  input  logic [WIDTH-1:0] Pin_data,
  output logic             Pin_ready,
  output logic             C1out_valid,
  output logic [WIDTH-1:0] C1out_data,
  input  logic             C1out_ready,
  output logic             C2out_valid,
  output logic [WIDTH-1:0] C2out_data,
  input  logic             C2out_ready,
  output logic             Pout_valid,
  output logic [WIDTH-1:0] Pout_data,
  input  logic             Pout_ready
`ifdef ROUTER_SCHED_STATS_EN
  ,
  output logic [15:0]      C1_gcnt,
  output logic [15:0]      C2_gcnt,
  output logic [15:0]      P_gcnt
`endif
);

  // Dest field occupies the top four bits; the child-select bit sits just below.
  localparam int c_DST_HI = WIDTH - 1;
  localparam int c_DST_LO = WIDTH - 4;
  localparam int c_SEL    = WIDTH - 5;

  logic             r_c1_valid, r_c2_valid, r_p_valid;
  logic [WIDTH-1:0] r_c1_data,  r_c2_data,  r_p_data;
  // Pointer 0 favours the first-listed source of each output's pair.
  logic             r_ptr_c1,   r_ptr_c2,   r_ptr_p;

  logic w_c1_local, w_c2_local;
  logic w_c1_req_c2, w_c1_req_p, w_c2_req_c1, w_c2_req_p, w_p_req_c1, w_p_req_c2;
  logic w_free_c1, w_free_c2, w_free_p;
  logic w_g_c1_from_c2, w_g_c1_from_p;
  logic w_g_c2_from_c1, w_g_c2_from_p;
  logic w_g_p_from_c1,  w_g_p_from_c2;
  logic w_gnt_c1, w_gnt_c2, w_gnt_p;

  // Route decode: children go down to the sibling when the packet is local,
  // otherwise up to P; the parent picks a child with the select bit.
  assign w_c1_local  = ((C1in_data[c_DST_HI:c_DST_LO] & MASK) == ADDRESS);
  assign w_c2_local  = ((C2in_data[c_DST_HI:c_DST_LO] & MASK) == ADDRESS);
  assign w_c1_req_c2 = C1in_valid &  w_c1_local;
  assign w_c1_req_p  = C1in_valid & ~w_c1_local;
  assign w_c2_req_c1 = C2in_valid &  w_c2_local;
  assign w_c2_req_p  = C2in_valid & ~w_c2_local;
  assign w_p_req_c1  = Pin_valid  & ~Pin_data[c_SEL];
  assign w_p_req_c2  = Pin_valid  &  Pin_data[c_SEL];

  // A slot can take a new packet when empty or draining this cycle.
  assign w_free_c1 = ~r_c1_valid | C1out_ready;
  assign w_free_c2 = ~r_c2_valid | C2out_ready;
  assign w_free_p  = ~r_p_valid  | Pout_ready;

  // Per-output two-way arbitration; reset blocks every grant so no input
  // sees ready while _RESET is low.
  assign w_g_c1_from_c2 = _RESET & w_free_c1 & w_c2_req_c1 & (~w_p_req_c1  | ~r_ptr_c1);
  assign w_g_c1_from_p  = _RESET & w_free_c1 & w_p_req_c1  & (~w_c2_req_c1 |  r_ptr_c1);
  assign w_g_c2_from_c1 = _RESET & w_free_c2 & w_c1_req_c2 & (~w_p_req_c2  | ~r_ptr_c2);
  assign w_g_c2_from_p  = _RESET & w_free_c2 & w_p_req_c2  & (~w_c1_req_c2 |  r_ptr_c2);
  assign w_g_p_from_c1  = _RESET & w_free_p  & w_c1_req_p  & (~w_c2_req_p  | ~r_ptr_p);
  assign w_g_p_from_c2  = _RESET & w_free_p  & w_c2_req_p  & (~w_c1_req_p  |  r_ptr_p);

  assign w_gnt_c1 = w_g_c1_from_c2 | w_g_c1_from_p;
  assign w_gnt_c2 = w_g_c2_from_c1 | w_g_c2_from_p;
  assign w_gnt_p  = w_g_p_from_c1  | w_g_p_from_c2;

  // Each input targets one output, so its ready is the OR of its two grants.
  assign C1in_ready = w_g_c2_from_c1 | w_g_p_from_c1;
  assign C2in_ready = w_g_c1_from_c2 | w_g_p_from_c2;
  assign Pin_ready  = w_g_c1_from_p  | w_g_c2_from_p;

  assign C1out_valid = r_c1_valid;
  assign C1out_data  = r_c1_data;
  assign C2out_valid = r_c2_valid;
  assign C2out_data  = r_c2_data;
  assign Pout_valid  = r_p_valid;
  assign Pout_data   = r_p_data;

  // Output registers and round-robin pointers; a grant loads the slot and
  // hands priority to the other source, otherwise a drain empties it.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      r_c1_valid <= 1'b0;
      r_c2_valid <= 1'b0;
      r_p_valid  <= 1'b0;
      r_c1_data  <= '0;
      r_c2_data  <= '0;
      r_p_data   <= '0;
      r_ptr_c1   <= 1'b0;
      r_ptr_c2   <= 1'b0;
      r_ptr_p    <= 1'b0;
    end else begin
      if (w_gnt_c1) begin
        r_c1_valid <= 1'b1;
        r_c1_data  <= w_g_c1_from_p ? Pin_data : C2in_data;
        r_ptr_c1   <= w_g_c1_from_c2;
      end else if (C1out_ready) begin
        r_c1_valid <= 1'b0;
      end
      if (w_gnt_c2) begin
        r_c2_valid <= 1'b1;
        r_c2_data  <= w_g_c2_from_p ? Pin_data : C1in_data;
        r_ptr_c2   <= w_g_c2_from_c1;
      end else if (C2out_ready) begin
        r_c2_valid <= 1'b0;
      end
      if (w_gnt_p) begin
        r_p_valid <= 1'b1;
        r_p_data  <= w_g_p_from_c2 ? C2in_data : C1in_data;
        r_ptr_p   <= w_g_p_from_c1;
      end else if (Pout_ready) begin
        r_p_valid <= 1'b0;
      end
    end
  end

`ifdef ROUTER_SCHED_STATS_EN
  logic [15:0] r_c1_gcnt, r_c2_gcnt, r_p_gcnt;

  // Saturating grant counters, one per output.
  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      r_c1_gcnt <= 16'd0;
      r_c2_gcnt <= 16'd0;
      r_p_gcnt  <= 16'd0;
    end else begin
      if (w_gnt_c1 && (r_c1_gcnt != 16'hFFFF)) r_c1_gcnt <= r_c1_gcnt + 16'd1;
      if (w_gnt_c2 && (r_c2_gcnt != 16'hFFFF)) r_c2_gcnt <= r_c2_gcnt + 16'd1;
      if (w_gnt_p  && (r_p_gcnt  != 16'hFFFF)) r_p_gcnt  <= r_p_gcnt  + 16'd1;
    end
  end

  assign C1_gcnt = r_c1_gcnt;
  assign C2_gcnt = r_c2_gcnt;
  assign P_gcnt  = r_p_gcnt;
`else
  // Grant statistics are not kept in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_router_sched                                            |
// | Description : Self-checking bench for router_sched: table of per-cycle   |
// |               stimulus with expected readies, per-output scoreboard      |
// |               queues for packet data, hand sequences for reset and the   |
// |               optional ROUTER_SCHED_STATS_EN counters.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_router_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c1v, c2v, pv;
  logic [8:0] c1d, c2d, pd;
  logic       c1or, c2or, por;
  logic       C1in_ready, C2in_ready, Pin_ready;
  logic       C1out_valid, C2out_valid, Pout_valid;
  logic [8:0] C1out_data, C2out_data, Pout_data;
`ifdef ROUTER_SCHED_STATS_EN
  logic [15:0] C1_gcnt, C2_gcnt, P_gcnt;
`endif

  always #5 clk = ~clk;

  router_sched #(.WIDTH(9), .ADDRESS(4'b1000), .MASK(4'b1000)) dut (
    .CLK(clk), ._RESET(rst_n),
    .C1in_valid(c1v), .C1in_data(c1d), .C1in_ready(C1in_ready),
    .C2in_valid(c2v), .C2in_data(c2d), .C2in_ready(C2in_ready),
    .Pin_valid(pv),   .Pin_data(pd),   .Pin_ready(Pin_ready),
    .C1out_valid(C1out_valid), .C1out_data(C1out_data), .C1out_ready(c1or),
    .C2out_valid(C2out_valid), .C2out_data(C2out_data), .C2out_ready(c2or),
    .Pout_valid(Pout_valid),   .Pout_data(Pout_data),   .Pout_ready(por)
`ifdef ROUTER_SCHED_STATS_EN
    , .C1_gcnt(C1_gcnt), .C2_gcnt(C2_gcnt), .P_gcnt(P_gcnt)
`endif
  );

  // One cycle of stimulus; orr = {C1out,C2out,Pout}_ready, er = expected {C1in,C2in,Pin}_ready.
  typedef struct {
    logic       rst_n;
    logic       c1v; logic [8:0] c1d;
    logic       c2v; logic [8:0] c2d;
    logic       pv;  logic [8:0] pd;
    logic [2:0] orr;
    logic [2:0] er;
  } vec_t;

  vec_t       tbl [21];
  logic [8:0] sq  [3][$];   // 0=C1out, 1=C2out, 2=Pout
  logic       ov  [3];
  logic [8:0] od  [3];
  int         errors = 0;
  int         checks = 0;

  assign ov[0] = C1out_valid; assign od[0] = C1out_data;
  assign ov[1] = C2out_valid; assign od[1] = C2out_data;
  assign ov[2] = Pout_valid;  assign od[2] = Pout_data;

  function automatic vec_t mk(input logic r, input logic a, input logic [8:0] ad,
                              input logic b, input logic [8:0] bd,
                              input logic p, input logic [8:0] ppd,
                              input logic [2:0] orr, input logic [2:0] er);
    vec_t v;
    v.rst_n = r; v.c1v = a; v.c1d = ad; v.c2v = b; v.c2d = bd;
    v.pv = p; v.pd = ppd; v.orr = orr; v.er = er;
    return v;
  endfunction

  function automatic logic is_local(input logic [8:0] d);
    return (d[8:5] & 4'b1000) == 4'b1000;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one vector after the rising edge, check at the falling edge, then
  // advance the scoreboard: drains pop, expected grants push.
  task automatic step(input string tag, input vec_t v, input bit zero_chk);
    string      nm [3];
    logic [2:0] rdy;
    logic       drain [3];
    nm[0] = "C1out"; nm[1] = "C2out"; nm[2] = "Pout";
    @(posedge clk); #1;
    rst_n = v.rst_n;
    c1v = v.c1v; c1d = v.c1d; c2v = v.c2v; c2d = v.c2d; pv = v.pv; pd = v.pd;
    c1or = v.orr[2]; c2or = v.orr[1]; por = v.orr[0];
    @(negedge clk);
    drain[0] = v.orr[2]; drain[1] = v.orr[1]; drain[2] = v.orr[0];
    for (int o = 0; o < 3; o++) begin
      chk($sformatf("%s %s_valid", tag, nm[o]), {15'd0, ov[o]}, {15'd0, sq[o].size() != 0});
      if (sq[o].size() != 0)
        chk($sformatf("%s %s_data", tag, nm[o]), {7'd0, od[o]}, {7'd0, sq[o][0]});
      if (zero_chk)
        chk($sformatf("%s %s_data_reset", tag, nm[o]), {7'd0, od[o]}, 16'd0);
    end
    rdy = {C1in_ready, C2in_ready, Pin_ready};
    chk($sformatf("%s in_ready", tag), {13'd0, rdy}, {13'd0, v.er});
    if (!v.rst_n) begin
      for (int o = 0; o < 3; o++) sq[o].delete();
    end else begin
      for (int o = 0; o < 3; o++)
        if (drain[o] && sq[o].size() != 0) void'(sq[o].pop_front());
      if (v.er[2]) begin
        if (is_local(v.c1d)) sq[1].push_back(v.c1d); else sq[2].push_back(v.c1d);
      end
      if (v.er[1]) begin
        if (is_local(v.c2d)) sq[0].push_back(v.c2d); else sq[2].push_back(v.c2d);
      end
      if (v.er[0]) begin
        if (v.pd[4]) sq[1].push_back(v.pd); else sq[0].push_back(v.pd);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; c1v = 1'b0; c2v = 1'b0; pv = 1'b0;
    c1d = '0; c2d = '0; pd = '0; c1or = 1'b1; c2or = 1'b1; por = 1'b1;

    // Routing, concurrency, round-robin and backpressure, from reset pointers.
    tbl[0]  = mk(1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 3'b111, 3'b000);
    tbl[1]  = mk(1, 1, 9'h1A0, 0, 9'h000, 0, 9'h000, 3'b111, 3'b100);
    tbl[2]  = mk(1, 1, 9'h0A0, 0, 9'h000, 0, 9'h000, 3'b111, 3'b100);
    tbl[3]  = mk(1, 0, 9'h000, 0, 9'h000, 1, 9'h000, 3'b111, 3'b001);
    tbl[4]  = mk(1, 0, 9'h000, 0, 9'h000, 1, 9'h010, 3'b111, 3'b001);
    tbl[5]  = mk(1, 1, 9'h1A0, 1, 9'h0A0, 1, 9'h000, 3'b111, 3'b111);
    tbl[6]  = mk(1, 1, 9'h0A1, 1, 9'h0A2, 0, 9'h000, 3'b111, 3'b100);
    tbl[7]  = mk(1, 1, 9'h0A3, 1, 9'h0A2, 0, 9'h000, 3'b111, 3'b010);
    tbl[8]  = mk(1, 1, 9'h0A3, 1, 9'h0A4, 0, 9'h000, 3'b111, 3'b100);
    tbl[9]  = mk(1, 0, 9'h000, 1, 9'h0A4, 0, 9'h000, 3'b111, 3'b010);
    tbl[10] = mk(1, 0, 9'h000, 1, 9'h100, 1, 9'h001, 3'b111, 3'b010);
    tbl[11] = mk(1, 0, 9'h000, 1, 9'h101, 1, 9'h001, 3'b111, 3'b001);
    tbl[12] = mk(1, 0, 9'h000, 1, 9'h101, 0, 9'h000, 3'b111, 3'b010);
    tbl[13] = mk(1, 1, 9'h1A5, 0, 9'h000, 1, 9'h012, 3'b111, 3'b001);
    tbl[14] = mk(1, 1, 9'h1A5, 0, 9'h000, 1, 9'h013, 3'b111, 3'b100);
    tbl[15] = mk(1, 0, 9'h000, 0, 9'h000, 1, 9'h013, 3'b111, 3'b001);
    tbl[16] = mk(1, 1, 9'h1A6, 0, 9'h000, 0, 9'h000, 3'b111, 3'b100);
    tbl[17] = mk(1, 1, 9'h1A0, 0, 9'h000, 0, 9'h000, 3'b101, 3'b000);
    tbl[18] = mk(1, 1, 9'h1A0, 0, 9'h000, 0, 9'h000, 3'b101, 3'b000);
    tbl[19] = mk(1, 1, 9'h1A0, 0, 9'h000, 0, 9'h000, 3'b111, 3'b100);
    tbl[20] = mk(1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 3'b111, 3'b000);

    // Reset state, with a valid input present to show ready is held low.
    step("rst0", mk(0, 1, 9'h1A0, 0, 9'h000, 0, 9'h000, 3'b111, 3'b000), 1'b1);
    step("rst1", mk(0, 1, 9'h1A0, 0, 9'h000, 0, 9'h000, 3'b111, 3'b000), 1'b1);

    for (int i = 0; i < 21; i++) step($sformatf("v%0d", i), tbl[i], 1'b0);

    // Reset with all three outputs full, then contention resumes from C1.
    step("h1", mk(1, 1, 9'h1A0, 1, 9'h0A0, 1, 9'h000, 3'b000, 3'b111), 1'b0);
    step("h2", mk(1, 1, 9'h1A1, 1, 9'h0A1, 1, 9'h001, 3'b000, 3'b000), 1'b0);
    step("h3", mk(0, 1, 9'h1A1, 1, 9'h0A1, 1, 9'h001, 3'b000, 3'b000), 1'b0);
    step("h4", mk(0, 1, 9'h1A1, 1, 9'h0A1, 1, 9'h001, 3'b111, 3'b000), 1'b1);
    step("h5", mk(1, 1, 9'h0A1, 1, 9'h0A2, 0, 9'h000, 3'b111, 3'b100), 1'b0);
    step("h6", mk(1, 1, 9'h0A3, 1, 9'h0A2, 0, 9'h000, 3'b111, 3'b010), 1'b0);
    step("h7", mk(1, 1, 9'h0A3, 0, 9'h000, 0, 9'h000, 3'b111, 3'b100), 1'b0);
    step("h8", mk(1, 0, 9'h000, 0, 9'h000, 0, 9'h000, 3'b111, 3'b000), 1'b0);

`ifdef ROUTER_SCHED_STATS_EN
    // Counters: clear, count a few grants, saturate, clear again.
    @(posedge clk); #1;
    rst_n = 1'b0; c1v = 1'b0; c2v = 1'b0; pv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; c1v = 1'b1; c1d = 9'h0A0; por = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("P_gcnt_5", P_gcnt, 16'd5);
    chk("C1_gcnt_0", C1_gcnt, 16'd0);
    chk("C2_gcnt_0", C2_gcnt, 16'd0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("P_gcnt_sat", P_gcnt, 16'hFFFF);
    rst_n = 1'b0; c1v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("P_gcnt_rst", P_gcnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
